// File: rtl/board_scan_driver.sv
// rtl/board_scan_driver.sv - Double-buffered LED matrix row scanner
module board_scan_driver #(
  parameter int         N      = 32,
  parameter logic [7:0] SPACE  = 8'd32,
  parameter int         CLKDIV = 2,
  parameter int         DWELL  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_row,
  input  logic [4:0] wr_col,
  input  logic [7:0] wr_char,
  input  logic       frame_done,
  output logic [4:0] led_row,
  output logic       led_sclk,
  output logic       led_sdo,
  output logic       led_latch,
  output logic       led_oe_n,
  output logic       swap_pulse,
  output logic       wr_overrun
);

  localparam int BITCYC = 2 * CLKDIV;
  localparam int CMAX   = (BITCYC > DWELL) ? BITCYC : DWELL;
  localparam int CW     = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_SHIFT, S_LATCH, S_DWELL} state_e;

  state_e        state_q, state_d;
  logic [4:0]    bit_q, bit_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [4:0]    row_q, row_d;
  logic          pending_q;
  logic          front_q, front_d;
  logic          displayed_q, displayed_d;
  logic          swap;
  logic          overrun_q;
  logic [4:0]    led_row_q;
  logic          led_sclk_q, led_sdo_q, led_latch_q, led_oe_n_q, swap_pulse_q;

  logic [N-1:0]  bank_q [2][N];
  logic [N-1:0]  front_row;

  // Writes always target the back bank; they are refused while a swap is pending.
  always_ff @(posedge clk) begin
    if (wr_en && !pending_q) begin
      bank_q[~front_q][wr_row][wr_col] <= (wr_char != SPACE);
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    row_d   = row_q;
    swap    = 1'b0;
    case (state_q)
      S_SHIFT: begin
        if (cyc_q == CW'(BITCYC - 1)) begin
          cyc_d = '0;
          if (bit_q == 5'(N - 1)) begin
            bit_d   = '0;
            state_d = S_LATCH;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_LATCH: begin
        state_d = S_DWELL;
        cyc_d   = '0;
      end
      S_DWELL: begin
        if (cyc_q == CW'(DWELL - 1)) begin
          cyc_d   = '0;
          state_d = S_SHIFT;
          if (row_q == 5'(N - 1)) begin
            row_d = '0;
            swap  = pending_q;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = S_SHIFT;
    endcase
    front_d     = front_q ^ swap;
    displayed_d = displayed_q | swap;
    front_row   = bank_q[front_d][row_d];
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_SHIFT;
      bit_q        <= '0;
      cyc_q        <= '0;
      row_q        <= '0;
      pending_q    <= 1'b0;
      front_q      <= 1'b0;
      displayed_q  <= 1'b0;
      overrun_q    <= 1'b0;
      led_row_q    <= '0;
      led_sclk_q   <= 1'b0;
      led_sdo_q    <= 1'b0;
      led_latch_q  <= 1'b0;
      led_oe_n_q   <= 1'b1;
      swap_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      cyc_q       <= cyc_d;
      row_q       <= row_d;
      front_q     <= front_d;
      displayed_q <= displayed_d;
      if (swap) begin
        pending_q <= 1'b0;
      end else if (frame_done) begin
        pending_q <= 1'b1;
      end
      if (wr_en && pending_q) begin
        overrun_q <= 1'b1;
      end
      led_sclk_q  <= (state_d == S_SHIFT) && (cyc_d >= CW'(CLKDIV));
      led_sdo_q   <= (state_d == S_SHIFT) && displayed_d && front_row[bit_d];
      led_latch_q <= (state_d == S_LATCH);
      if (state_d == S_LATCH) begin
        led_row_q <= row_d;
      end
      // Blank until a complete board has been swapped in at least once.
      led_oe_n_q   <= !((state_d == S_DWELL) && displayed_d);
      swap_pulse_q <= swap;
    end
  end

  assign led_row    = led_row_q;
  assign led_sclk   = led_sclk_q;
  assign led_sdo    = led_sdo_q;
  assign led_latch  = led_latch_q;
  assign led_oe_n   = led_oe_n_q;
  assign swap_pulse = swap_pulse_q;
  assign wr_overrun = overrun_q;

endmodule

// File: tb/tb_board_scan_driver.sv
// tb/tb_board_scan_driver.sv - Directed self-checking bench for board_scan_driver
`timescale 1ns/1ps
module tb_board_scan_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_row = '0;
  logic [4:0] wr_col = '0;
  logic [7:0] wr_char = '0;
  logic       frame_done = 1'b0;
  logic [4:0] led_row;
  logic       led_sclk, led_sdo, led_latch, led_oe_n, swap_pulse, wr_overrun;

  int checks = 0;
  int errors = 0;

  board_scan_driver dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_char(wr_char), .frame_done(frame_done), .led_row(led_row), .led_sclk(led_sclk),
    .led_sdo(led_sdo), .led_latch(led_latch), .led_oe_n(led_oe_n),
    .swap_pulse(swap_pulse), .wr_overrun(wr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: reconstructs each shifted row and per-row timing.
  logic [31:0] row_word [32];
  int          row_sclk [32];
  int          row_dwell [32];
  logic [31:0] cur_word = '0;
  int bit_idx = 0, sclk_cnt = 0, oe_cnt = 0, per_cnt = 0;
  int per_min = 0, per_max = 0, latch_cnt = 0, swap_cnt = 0;
  int oe_total = 0, oe_viol = 0, last_row = 0;
  bit prev_sclk = 1'b0, have_latch = 1'b0;

  always @(negedge clk) begin
    if (swap_pulse) swap_cnt++;
    if (!led_oe_n) oe_total++;
    if (reset) begin
      prev_sclk = 1'b0; cur_word = '0; bit_idx = 0; sclk_cnt = 0;
      oe_cnt = 0; per_cnt = 0; have_latch = 1'b0;
    end else begin
      per_cnt++;
      if (!led_oe_n) oe_cnt++;
      if ((led_latch || led_sclk) && !led_oe_n) oe_viol++;
      if (led_sclk && !prev_sclk) begin
        if (bit_idx < 32) cur_word[bit_idx] = led_sdo;
        bit_idx++;
        sclk_cnt++;
      end
      prev_sclk = led_sclk;
      if (led_latch) begin
        row_word[led_row] = cur_word;
        row_sclk[led_row] = sclk_cnt;
        if (have_latch) begin
          row_dwell[last_row] = oe_cnt;
          if (per_cnt < per_min) per_min = per_cnt;
          if (per_cnt > per_max) per_max = per_cnt;
        end
        have_latch = 1'b1;
        last_row = int'(led_row);
        latch_cnt++;
        per_cnt = 0; cur_word = '0; bit_idx = 0; sclk_cnt = 0; oe_cnt = 0;
      end
    end
  end

  task automatic clear_stats();
    for (int i = 0; i < 32; i++) begin
      row_word[i] = 32'hDEADBEEF;
      row_sclk[i] = -1;
      row_dwell[i] = -1;
    end
    per_min = 1 << 30;
    per_max = 0;
    oe_viol = 0;
  endtask

  task automatic wait_latches(input int n, input string tag);
    int target = latch_cnt + n;
    int cyc = 0;
    while (latch_cnt < target && cyc < n * 193 + 400) begin
      @(posedge clk);
      cyc++;
    end
    check_eq({tag, "_latch_wait"}, 32'(latch_cnt >= target), 1);
  endtask

  task automatic wait_swap(input string tag);
    int base = swap_cnt;
    int cyc = 0;
    while (swap_cnt == base && cyc < 8000) begin
      @(posedge clk);
      cyc++;
    end
    check_eq({tag, "_swap_wait"}, 32'(swap_cnt != base), 1);
  endtask

  task automatic wait_row(input int r, input string tag);
    int seen = latch_cnt;
    int cyc = 0;
    bit hit = 1'b0;
    while (!hit && cyc < 8000) begin
      @(posedge clk);
      cyc++;
      if (latch_cnt != seen) begin
        seen = latch_cnt;
        hit = (last_row == r);
      end
    end
    check_eq({tag, "_row_wait"}, 32'(hit), 1);
  endtask

  task automatic write_board(input logic [7:0] fill, input int sr, input int sc,
                             input logic [7:0] sch, input bit fd_last);
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        @(negedge clk);
        wr_en = 1'b1;
        wr_row = 5'(r);
        wr_col = 5'(c);
        wr_char = (r == sr && c == sc) ? sch : fill;
        frame_done = fd_last && (r == 31) && (c == 31);
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic pulse_frame_done();
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int hr, input int hc, input logic [31:0] base);
    logic [31:0] exp_word;
    for (int r = 0; r < 32; r++) begin
      exp_word = base;
      if (r == hr) exp_word[hc] = 1'b1;
      check_eq($sformatf("%s_row%0d_word", tag, r), row_word[r], exp_word);
      check_eq($sformatf("%s_row%0d_sclk", tag, r), row_sclk[r], 32);
      check_eq($sformatf("%s_row%0d_dwell", tag, r), row_dwell[r], 64);
    end
    check_eq({tag, "_period_min"}, per_min, 193);
    check_eq({tag, "_period_max"}, per_max, 193);
    check_eq({tag, "_oe_in_shift"}, oe_viol, 0);
  endtask

  initial begin
    int base_swap;
    int base_oe;

    repeat (3) @(negedge clk);
    check_eq("rst_led_row", led_row, 0);
    check_eq("rst_led_sclk", led_sclk, 0);
    check_eq("rst_led_sdo", led_sdo, 0);
    check_eq("rst_led_latch", led_latch, 0);
    check_eq("rst_led_oe_n", led_oe_n, 1);
    check_eq("rst_swap_pulse", swap_pulse, 0);
    check_eq("rst_wr_overrun", wr_overrun, 0);
    reset = 1'b0;

    // Blank scanning before any board has been delivered.
    clear_stats();
    wait_latches(3, "t1");
    check_eq("t1_period_min", per_min, 193);
    check_eq("t1_period_max", per_max, 193);
    check_eq("t1_sclk", row_sclk[last_row], 32);
    check_eq("t1_oe_blank", oe_total, 0);

    // Full board of 'J', frame_done coinciding with the last write.
    base_swap = swap_cnt;
    write_board(8'd74, -1, -1, 8'd0, 1'b1);
    wait_swap("t2");
    check_eq("t2_swap_after_row31", last_row, 31);
    clear_stats();
    wait_latches(33, "t2");
    check_frame("t2", -1, 0, 32'hFFFFFFFF);
    check_eq("t2_swap_count", swap_cnt - base_swap, 1);

    // Single lit cell (3,5).
    write_board(8'd32, 3, 5, 8'd88, 1'b0);
    pulse_frame_done();
    wait_swap("t3");
    clear_stats();
    wait_latches(33, "t3");
    check_frame("t3", 3, 5, 32'h0);

    // Dropped write while swap pending, plus a redundant frame_done.
    write_board(8'd32, -1, -1, 8'd0, 1'b0);
    wait_row(5, "t4");
    base_swap = swap_cnt;
    pulse_frame_done();
    wr_en = 1'b1; wr_row = 5'd7; wr_col = 5'd9; wr_char = 8'd88;
    @(negedge clk);
    wr_en = 1'b0;
    check_eq("t4_overrun_set", wr_overrun, 1);
    pulse_frame_done();
    wait_swap("t4");
    clear_stats();
    wait_latches(33, "t4");
    check_frame("t4", -1, 0, 32'h0);
    check_eq("t4_swap_count", swap_cnt - base_swap, 1);
    check_eq("t4_overrun_sticky", wr_overrun, 1);

    // Reset in the dwell of row 17.
    wait_row(17, "t5");
    repeat (10) @(posedge clk);
    #1;
    check_eq("t5_pre_oe_n", led_oe_n, 0);
    reset = 1'b1;
    #1;
    check_eq("t5_rst_oe_n", led_oe_n, 1);
    check_eq("t5_rst_led_row", led_row, 0);
    check_eq("t5_rst_overrun", wr_overrun, 0);
    check_eq("t5_rst_latch", led_latch, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base_oe = oe_total;
    clear_stats();
    wait_latches(1, "t5a");
    check_eq("t5_first_row", last_row, 0);
    check_eq("t5_first_sclk", row_sclk[0], 32);
    wait_latches(32, "t5b");
    check_eq("t5_oe_blank", oe_total - base_oe, 0);
    pulse_frame_done();
    wait_swap("t5");
    clear_stats();
    wait_latches(2, "t5c");
    check_eq("t5_dwell_restored", row_dwell[0], 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_scan_driver.md
BOARD_SCAN_DRIVER -- requirements
Module: board_scan_driver

Interface
REQ-001 Parameter N, default 32: board dimension in rows and columns.
REQ-002 Parameter SPACE, default 8'd32: character code for an unlit cell.
REQ-003 Parameter CLKDIV, default 2: clk cycles per led_sclk half-period, valid range 1 or more.
REQ-004 Parameter DWELL, default 64: clk cycles per row with output enabled, valid range 1 or more.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 wr_en  in  1  one-cycle strobe; a board cell is valid on wr_row/wr_col/wr_char.
REQ-008 wr_row  in  5  row index of written cell, 0..N-1.
REQ-009 wr_col  in  5  column index of written cell, 0..N-1.
REQ-010 wr_char  in  8  character code of written cell.
REQ-011 frame_done  in  1  one-cycle strobe; the SPI slave has delivered a complete board.
REQ-012 led_row  out  5  row address driven to the matrix.
REQ-013 led_sclk  out  1  column shift-register clock.
REQ-014 led_sdo  out  1  column shift-register data; 1 = lit.
REQ-015 led_latch  out  1  one-cycle column latch pulse.
REQ-016 led_oe_n  out  1  active-low matrix output enable.
REQ-017 swap_pulse  out  1  one-cycle pulse when the back bank becomes the front bank.
REQ-018 wr_overrun  out  1  sticky flag: a write was dropped.

Function
REQ-019 The block SHALL hold two N*N one-bit banks (front, back); a cell's bit SHALL be stored as 1 exactly when wr_char != SPACE.
REQ-020 On wr_en with no swap pending, the addressed bit of the back bank SHALL be written on that clk edge; out-of-range indices SHALL NOT arise and need no handling.
REQ-021 frame_done SHALL set swap_pending; frame_done while swap_pending is already set SHALL have no further effect.
REQ-022 While swap_pending is set, wr_en SHALL be dropped and SHALL set wr_overrun.
REQ-023 wr_en and frame_done in the same cycle with no swap pending: the write SHALL land in the back bank before the swap takes effect.
REQ-024 Scan FSM states: SHIFT, LATCH, DWELL.
REQ-025 SHIFT: N bits of the front bank row scan_row SHALL be emitted, column 0 first; each bit occupies 2*CLKDIV cycles, with led_sclk low for the first CLKDIV cycles and high for the last CLKDIV cycles; led_sdo SHALL be stable for the whole bit period; led_oe_n SHALL be 1.
REQ-026 After the last bit, the FSM SHALL enter LATCH for exactly one cycle: led_latch=1, led_sclk=0, led_oe_n=1, led_row updated to scan_row.
REQ-027 DWELL: led_oe_n SHALL be 0 for DWELL cycles, then scan_row SHALL increment, wrapping from N-1 to 0, and the FSM SHALL re-enter SHIFT.
REQ-028 Row period SHALL be N*2*CLKDIV + 1 + DWELL cycles; with defaults this is 193.
REQ-029 The bank swap SHALL occur only on the DWELL-exit edge where scan_row wraps from N-1 to 0 with swap_pending set; on that edge the banks SHALL exchange roles, swap_pending SHALL clear, and swap_pulse SHALL be 1 for the following cycle.
REQ-030 Before the first swap after reset, led_oe_n SHALL remain 1 in DWELL, so an undefined board is never displayed; scan timing SHALL otherwise run normally.

Reset
REQ-031 On reset assertion, outputs SHALL go immediately to: led_row=0, led_sclk=0, led_sdo=0, led_latch=0, led_oe_n=1, swap_pulse=0, wr_overrun=0.
REQ-032 Reset SHALL also set FSM=SHIFT, scan_row=0, bit and cycle counters=0, swap_pending=0, and the "displayed" flag=0; bank contents need not be reset.
REQ-033 Reset asserted mid-SHIFT or mid-DWELL SHALL abort the row; after release, scanning SHALL restart at row 0, bit 0.

Verification
REQ-034 Reset, then write all 1024 cells with 'J' (8'd74) and pulse frame_done -> one swap_pulse at the first row-31-to-0 wrap; thereafter led_sdo=1 on all 32 bits of every row and led_oe_n=0 for 64 cycles per row.
REQ-035 Write only cell (3,5)='X', others SPACE, then swap -> for led_row=3, bit 5 is the only 1; all other rows shift all zeros.
REQ-036 Measure the defaults -> led_latch pulses exactly 193 cycles apart; exactly 32 led_sclk rising edges occur between latches; led_oe_n=1 throughout SHIFT and LATCH.
REQ-037 Pulse frame_done, then wr_en before the swap -> wr_overrun=1 until reset; the dropped cell is absent after the swap; a second frame_done before the swap yields only one swap_pulse.
REQ-038 Assert reset during DWELL of row 17 -> led_oe_n=1 and led_row=0 immediately; led_oe_n stays 1 after release until a new frame_done and swap occur.
